priority_arbiter: RTL and testbench

Parametrised, registered successor to the team's 8-to-3 combinational priority encoder. Takes N request lines, selects one winner under either fixed priority (highest index wins) or round-robin policy, and holds a registered grant (index, one-hot, valid) until the granted client releases it. Sits between shared-resource clients and the resource's select mux.

---
 rtl/prio_arb_pkg.sv | 12 +
 rtl/priority_arbiter_pick.sv | 25 ++
 rtl/priority_arbiter.sv | 130 +++++++++++++
 tb/tb_priority_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared types and constants for the priority arbiter
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/priority_arbiter_pick.sv
// rtl/priority_arbiter_pick.sv - combinational highest-set-bit finder (module prio_pick)
module prio_pick #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // Ascending scan so the last hit, i.e. the highest index, wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = i[W-1:0];
      end
    end
    onehot = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - registered fixed/round-robin arbiter; optional timeout via PRIO_ARB_TIMEOUT_EN
module priority_arbiter
  import prio_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int RR       = MODE_FIXED,
  parameter int MAX_HOLD = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic         valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_oh,
  output logic         expired
);

  state_t       state, state_next;
  logic         pick_found;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_oh;
  logic         timeout;
  logic         end_grant;
  logic         load;
  logic         clear;

  logic         valid_d;
  logic [W-1:0] grant_idx_d;
  logic [N-1:0] grant_oh_d;
  logic         expired_d;

  if (N < 2 || N > 64 || MAX_HOLD < 1) begin : g_bad_param
    $error("priority_arbiter: parameter out of range");
  end

  if (RR == MODE_RR) begin : g_rr
    logic [N-1:0] mask;
    logic [N-1:0] mask_next;
    logic         m_found, u_found;
    logic [W-1:0] m_idx, u_idx;
    logic [N-1:0] m_oh, u_oh;

    prio_pick #(.N(N)) u_pick_masked (
      .req(req & mask), .found(m_found), .idx(m_idx), .onehot(m_oh)
    );
    prio_pick #(.N(N)) u_pick_unmasked (
      .req(req), .found(u_found), .idx(u_idx), .onehot(u_oh)
    );

    assign pick_found = u_found;
    assign pick_idx   = m_found ? m_idx : u_idx;
    assign pick_oh    = m_found ? m_oh  : u_oh;
    // Only clients below the last winner stay eligible first; zero mask wraps to the top.
    assign mask_next  = (N'(1) << pick_idx) - N'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)       mask <= '1;
      else if (load) mask <= mask_next;
    end
  end else begin : g_fixed
    prio_pick #(.N(N)) u_pick (
      .req(req), .found(pick_found), .idx(pick_idx), .onehot(pick_oh)
    );
  end

`ifdef PRIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  assign timeout = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  hold_cnt <= '0;
    else if (load)            hold_cnt <= CW'(1);
    else if (clear)           hold_cnt <= '0;
    else if (state == GRANT)  hold_cnt <= hold_cnt + CW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  assign end_grant = rel | timeout;
  assign load  = en && pick_found && ((state == IDLE) || end_grant);
  assign clear = (state == GRANT) && end_grant && !(en && pick_found);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load)       state_next = GRANT;
    else if (clear) state_next = IDLE;
  end

  always_comb begin
    valid_d     = valid;
    grant_idx_d = grant_idx;
    grant_oh_d  = grant_oh;
    expired_d   = (state == GRANT) && timeout && !rel;
    if (load) begin
      valid_d     = 1'b1;
      grant_idx_d = pick_idx;
      grant_oh_d  = pick_oh;
    end else if (clear) begin
      valid_d     = 1'b0;
      grant_idx_d = '0;
      grant_oh_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      grant_idx <= '0;
      grant_oh  <= '0;
      expired   <= 1'b0;
    end else begin
      valid     <= valid_d;
      grant_idx <= grant_idx_d;
      grant_oh  <= grant_oh_d;
      expired   <= expired_d;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - directed self-checking bench for priority_arbiter (fixed and RR instances)
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;

  logic       f_valid, r_valid, f_exp, r_exp;
  logic [2:0] f_idx, r_idx;
  logic [7:0] f_oh, r_oh;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef PRIO_ARB_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 10;
`endif

  always #5 clk = ~clk;

  priority_arbiter #(.N(8), .RR(0), .MAX_HOLD(4)) u_fix (
    .clk(clk), .rst(rst), .en(en), .req(req), .rel(rel),
    .valid(f_valid), .grant_idx(f_idx), .grant_oh(f_oh), .expired(f_exp)
  );

  priority_arbiter #(.N(8), .RR(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .en(en), .req(req), .rel(rel),
    .valid(r_valid), .grant_idx(r_idx), .grant_oh(r_oh), .expired(r_exp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00; rel = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL reset_f_valid: got %b want 0", f_valid); else pass_cnt++;
    total_cnt++; if (f_idx !== 3'd0) $display("FAIL reset_f_idx: got %0d want 0", f_idx); else pass_cnt++;
    total_cnt++; if (f_oh !== 8'h00) $display("FAIL reset_f_oh: got %h want 00", f_oh); else pass_cnt++;
    total_cnt++; if (f_exp !== 1'b0) $display("FAIL reset_f_exp: got %b want 0", f_exp); else pass_cnt++;
    total_cnt++; if (r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", r_valid); else pass_cnt++;
  endtask

  task automatic test_fixed_hold();
    do_reset();
    en = 1'b1; req = 8'h7F;
    step();
    total_cnt++; if (f_valid !== 1'b1) $display("FAIL fix_grant_valid: got %b want 1", f_valid); else pass_cnt++;
    total_cnt++; if (f_idx !== 3'd6) $display("FAIL fix_grant_idx: got %0d want 6", f_idx); else pass_cnt++;
    total_cnt++; if (f_oh !== 8'h40) $display("FAIL fix_grant_oh: got %h want 40", f_oh); else pass_cnt++;
    req = 8'h81;
    for (int c = 0; c < HOLD; c++) begin
      step();
      if (c == 2) req = 8'h00;
      total_cnt++;
      if (f_valid !== 1'b1 || f_idx !== 3'd6 || f_oh !== 8'h40 || f_exp !== 1'b0)
        $display("FAIL fix_hold cycle %0d: got v=%b idx=%0d oh=%h exp=%b want v=1 idx=6 oh=40 exp=0",
                 c, f_valid, f_idx, f_oh, f_exp);
      else pass_cnt++;
    end
    req = 8'h00; rel = 1'b1;
    step();
    rel = 1'b0;
    total_cnt++; if (f_valid !== 1'b0 || f_oh !== 8'h00) $display("FAIL fix_release: got v=%b oh=%h want v=0 oh=00", f_valid, f_oh); else pass_cnt++;
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; req = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      total_cnt++; if (f_valid !== 1'b0 || r_valid !== 1'b0) $display("FAIL en_low cycle %0d: got f=%b r=%b want 0", c, f_valid, r_valid); else pass_cnt++;
    end
    en = 1'b1;
    step();
    total_cnt++; if (f_valid !== 1'b1 || f_idx !== 3'd7) $display("FAIL en_rise: got v=%b idx=%0d want v=1 idx=7", f_valid, f_idx); else pass_cnt++;
  endtask

  task automatic test_rr_rotation();
    logic [2:0] e;
    do_reset();
    en = 1'b1; req = 8'hFF;
    step();
    total_cnt++; if (r_valid !== 1'b1 || r_idx !== 3'd7) $display("FAIL rr_first: got v=%b idx=%0d want v=1 idx=7", r_valid, r_idx); else pass_cnt++;
    rel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      e = 3'(15 - k);
      total_cnt++;
      if (r_valid !== 1'b1 || r_idx !== e || r_oh !== (8'h01 << e))
        $display("FAIL rr_seq step %0d: got v=%b idx=%0d oh=%h want v=1 idx=%0d", k, r_valid, r_idx, r_oh, e);
      else pass_cnt++;
      total_cnt++; if (f_valid !== 1'b1 || f_idx !== 3'd7) $display("FAIL fix_regrant step %0d: got v=%b idx=%0d want v=1 idx=7", k, f_valid, f_idx); else pass_cnt++;
    end
    rel = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1; req = 8'h06;
    step();
    total_cnt++; if (f_idx !== 3'd2 || f_valid !== 1'b1) $display("FAIL b2b_first: got v=%b idx=%0d want v=1 idx=2", f_valid, f_idx); else pass_cnt++;
    req = 8'h02; rel = 1'b1;
    step();
    total_cnt++; if (f_valid !== 1'b1 || f_idx !== 3'd1 || f_oh !== 8'h02) $display("FAIL b2b_second: got v=%b idx=%0d oh=%h want v=1 idx=1 oh=02", f_valid, f_idx, f_oh); else pass_cnt++;
    req = 8'h00; rel = 1'b1;
    step();
    total_cnt++; if (f_valid !== 1'b0 || f_oh !== 8'h00 || f_idx !== 3'd0) $display("FAIL b2b_end: got v=%b idx=%0d oh=%h want v=0 idx=0 oh=00", f_valid, f_idx, f_oh); else pass_cnt++;
    step();
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL idle_rel_ignored: got v=%b want 0", f_valid); else pass_cnt++;
    rel = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; req = 8'hFF;
    step();
    rel = 1'b1;
    step();
    rel = 1'b0;
    total_cnt++; if (r_idx !== 3'd6) $display("FAIL arst_pre: got idx=%0d want 6", r_idx); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (r_valid !== 1'b0 || r_idx !== 3'd0 || r_oh !== 8'h00 || f_valid !== 1'b0 || f_oh !== 8'h00)
      $display("FAIL arst_immediate: got rv=%b ridx=%0d roh=%h fv=%b foh=%h want all 0", r_valid, r_idx, r_oh, f_valid, f_oh);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    step();
    total_cnt++; if (r_valid !== 1'b1 || r_idx !== 3'd7) $display("FAIL arst_restart: got v=%b idx=%0d want v=1 idx=7", r_valid, r_idx); else pass_cnt++;
  endtask

`ifdef PRIO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    en = 1'b1; req = 8'h10;
    step();
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (f_valid !== 1'b1 || f_idx !== 3'd4 || f_exp !== 1'b0)
        $display("FAIL to_hold cycle %0d: got v=%b idx=%0d exp=%b want v=1 idx=4 exp=0", c, f_valid, f_idx, f_exp);
      else pass_cnt++;
      if (c < 3) step();
    end
    step();
    total_cnt++; if (f_exp !== 1'b1 || f_valid !== 1'b1 || f_idx !== 3'd4) $display("FAIL to_expire: got exp=%b v=%b idx=%0d want exp=1 v=1 idx=4", f_exp, f_valid, f_idx); else pass_cnt++;
    step();
    total_cnt++; if (f_exp !== 1'b0) $display("FAIL to_pulse_width: got exp=%b want 0", f_exp); else pass_cnt++;
    step();
    step();
    rel = 1'b1;
    step();
    rel = 1'b0;
    total_cnt++; if (f_exp !== 1'b0 || f_valid !== 1'b1 || f_idx !== 3'd4) $display("FAIL to_rel_wins: got exp=%b v=%b idx=%0d want exp=0 v=1 idx=4", f_exp, f_valid, f_idx); else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    en = 1'b1; req = 8'h10;
    step();
    for (int c = 0; c < 20; c++) begin
      step();
      total_cnt++;
      if (f_valid !== 1'b1 || f_idx !== 3'd4 || f_exp !== 1'b0 || r_exp !== 1'b0)
        $display("FAIL no_timeout cycle %0d: got v=%b idx=%0d fexp=%b rexp=%b want v=1 idx=4 exp=0", c, f_valid, f_idx, f_exp, r_exp);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_hold();
    test_enable();
    test_rr_rotation();
    test_back_to_back();
    test_async_reset();
`ifdef PRIO_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
